// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Purpose  : Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
//             DIV/DIVU/REM/REMU) with a tagged valid/ready request/response
//             handshake, flush and response backpressure. One op in flight.
//             Multiply: radix-2 shift-add. Divide: restoring, 1 bit/cycle.
//  Options  : MULDIV_EARLY_OUT_EN - early exit for multiply once the remaining
//             multiplier bits are zero, and division skip when |rs1| < |rs2|.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;       // remaining CALC iterations
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;     // negate product / quotient in FIX
    logic             neg_r;     // negate remainder in FIX
    logic [XLEN-1:0]  opnd;      // multiplicand (mul) or divisor (div), magnitude
    logic [XLEN-1:0]  hi;        // product high half / partial remainder
    logic [XLEN-1:0]  lo;        // multiplier+product low half / dividend+quotient

    // ------------------------------------------------------------------
    // Request decode: signedness, magnitudes and special-case detection
    // ------------------------------------------------------------------
    logic            is_div;
    logic            sgn1, sgn2;
    logic            neg1, neg2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_val;

    // Decode the incoming request combinationally for use at the accept edge.
    always_comb begin
        is_div = req_op[2];
        if (is_div) begin
            sgn1 = ~req_op[0];
            sgn2 = ~req_op[0];
        end else begin
            sgn1 = (req_op[1:0] != 2'b11);
            sgn2 = ~req_op[1];
        end
        neg1 = sgn1 & req_rs1[XLEN-1];
        neg2 = sgn2 & req_rs2[XLEN-1];
        abs1 = neg1 ? (-req_rs1) : req_rs1;
        abs2 = neg2 ? (-req_rs2) : req_rs2;

        div_zero = is_div && (req_rs2 == '0);
        div_ovf  = is_div && !req_op[0] && (req_rs1 == MIN_VAL) && (req_rs2 == '1);
        special  = div_zero || div_ovf;

        if (div_zero) begin
            special_val = req_op[1] ? req_rs1 : '1;
        end else begin
            special_val = req_op[1] ? '0 : req_rs1;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic div_skip;

    // A dividend smaller than the divisor needs no iterations at all.
    always_comb begin
        div_skip = is_div && (abs1 < abs2);
    end
`endif

    // ------------------------------------------------------------------
    // One iteration of the shift-add multiplier or restoring divider
    // ------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;

    // Next accumulator contents for the current CALC cycle.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[XLEN];
        if (op_q[2]) begin
            hi_nxt = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] mul_rest_mask;
    logic            mul_rest_zero;

    // The unconsumed multiplier bits sit in the low (cnt-1) bits of lo_nxt.
    always_comb begin
        mul_rest_mask = ~({XLEN{1'b1}} << (cnt - CNT_W'(1)));
        mul_rest_zero = ((lo_nxt & mul_rest_mask) == '0);
    end
`endif

    // ------------------------------------------------------------------
    // FIX: align, apply sign and select the architectural result
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Final sign correction and result selection from the accumulator.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        // An early exit leaves the product cnt positions too far left.
        prod_full = {hi, lo} >> cnt;
`else
        prod_full = {hi, lo};
`endif
        prod_fix = neg_q ? (-prod_full) : prod_full;
        quo_fix  = neg_q ? (-lo) : lo;
        rem_fix  = neg_r ? (-hi) : hi;
        case (op_q)
            3'b000:                fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        fix_result = quo_fix;
            default:               fix_result = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM, datapath registers and response registers
    // ------------------------------------------------------------------
    // Sequence IDLE -> CALC -> FIX -> DONE, with flush and special shortcuts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_tag    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        op_q  <= req_op;
                        tag_q <= req_tag;
                        neg_q <= neg1 ^ neg2;
                        neg_r <= neg1;
                        cnt   <= CNT_W'(XLEN);
                        opnd  <= is_div ? abs2 : abs1;
                        hi    <= '0;
                        lo    <= is_div ? abs1 : abs2;
                        if (special) begin
                            state       <= S_DONE;
                            resp_valid  <= 1'b1;
                            resp_result <= special_val;
                            resp_tag    <= req_tag;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (div_skip) begin
                            // Quotient 0, remainder |rs1|.
                            state <= S_FIX;
                            hi    <= abs1;
                            lo    <= '0;
                        end
`endif
                        else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_FIX;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!op_q[2] && mul_rest_zero) begin
                            state <= S_FIX;
                        end
`endif
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        state       <= S_DONE;
                        resp_valid  <= 1'b1;
                        resp_result <= fix_result;
                        resp_tag    <= tag_q;
                    end
                end
                default: begin
                    // DONE: hold the response until accepted or flushed.
                    if (flush || resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_iter
//  Purpose  : Self-checking bench for muldiv_iter: directed vectors, special
//             cases, backpressure, flush, reset and randomized operations
//             against a behavioural arithmetic model.
//  Options  : MULDIV_EARLY_OUT_EN selects the early-out latency model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LIMIT = 200;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Architectural result of an M-extension op, from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accept cycle until resp_valid is seen.
    function automatic int lat_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = op[2] && ((b == 0) || (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF));
        if (special) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] ma, mb;
            bit          sg;
            int          k;
            if (op[2]) begin
                sg = !op[0];
                ma = (sg && a[31]) ? -a : a;
                mb = (sg && b[31]) ? -b : b;
                return (ma < mb) ? 2 : XLEN + 2;
            end
            sg = (op[1:0] == 2'b00) || (op[1:0] == 2'b01);
            mb = (sg && b[31]) ? -b : b;
            k = 1;
            for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
            return k + 2;
        end
`else
        return XLEN + 2;
`endif
    endfunction

    // Issue one request; returns after the accept edge (+1).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        int n;
        n = 0;
        while (!req_ready && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tg;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_tag   = 5'($urandom);
    endtask

    // Full transaction: issue, wait for response, optional stall, handshake.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input logic [31:0] exp_res, input int stall);
        int n;
        resp_ready = (stall == 0);
        issue(op, a, b, tg);
        n = 1;
        while (!resp_valid && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check("resp_valid_seen", resp_valid, 1'b1);
        check("latency", n, lat_model(op, a, b));
        check("result", resp_result, exp_res);
        check("tag", resp_tag, tg);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", resp_valid, 1'b1);
            check("stall_result", resp_result, exp_res);
            check("stall_tag", resp_tag, tg);
            check("stall_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", resp_valid, 1'b0);
        check("post_hs_ready", req_ready, 1'b1);
    endtask

    // Start a long op, abort it with flush or reset, verify it vanished.
    task automatic abort_test(input bit use_reset, input logic [4:0] tg);
        bit seen;
        issue(3'd3, $urandom, 32'h8000_0000 | $urandom, tg);
        repeat (9) begin @(posedge clk); #1; end
        check("abort_busy_before", busy, 1'b1);
        if (use_reset) rstn = 1'b0; else flush = 1'b1;
        @(posedge clk); #1;
        rstn  = 1'b1;
        flush = 1'b0;
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_resp_valid", resp_valid, 1'b0);
        if (use_reset) begin
            check("abort_rst_result", resp_result, 32'd0);
            check("abort_rst_tag", resp_tag, 5'd0);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("abort_no_resp", seen, 1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  tg;
        int          sel;
        bit          seen;

        rstn       = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_result", resp_result, 32'd0);
        check("rst_tag", resp_tag, 5'd0);
        check("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic vectors.
        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
        run_op(3'd1, 32'd7,         32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        0);
        run_op(3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         0);

        // Special cases.
        run_op(3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0);
        run_op(3'd7, 32'd5,         32'd0,         5'd14, 32'd5,         0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);

        // Backpressure.
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, ref_model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0), 10);

        // Flush in IDLE blocks the transfer.
        req_valid = 1'b1; flush = 1'b1;
        req_op = 3'd5; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd18;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_valid", resp_valid, 1'b0);
        check("idle_flush_busy", busy, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("idle_flush_no_resp", seen, 1'b0);

        // Randomized operations.
        for (int t = 0; t < 60; t++) begin
            op  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = MIN_VAL; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
                3: b = $urandom_range(1, 15);
                4: a = $urandom_range(0, 1000);
                default: ;
            endcase
            tg = 5'($urandom);
            run_op(op, a, b, tg, ref_model(op, a, b), $urandom_range(0, 3));
        end

        // Flush and reset mid-CALC, then a simple follow-up multiply.
        abort_test(1'b0, 5'd21);
        abort_test(1'b1, 5'd22);
        run_op(3'd0, 32'd3, 32'd4, 5'd23, 32'd12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
